// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues word fetches to instruction memory and hands
// {pc, instr} to decode in order through a small FIFO, flushing on EX redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   ifq      [FIFO_DEPTH];
  logic [PW-1:0] ifq_wr, ifq_rd;
  logic [31:0]   fq_pc    [FIFO_DEPTH];
  logic [31:0]   fq_instr [FIFO_DEPTH];
  logic [PW-1:0] fq_wr, fq_rd;
  logic [CW-1:0] fq_cnt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic          req_fire, rsp_fire, rsp_keep, pop;
  logic [CW:0]   credit_sum;
  logic          unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign credit_sum     = {1'b0, outstanding} + {1'b0, fq_cnt};
  assign imem_req_valid = rst_n & clk_en & ~redirect_valid & (credit_sum < DEPTH_L);
  assign imem_req_addr  = pc;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = clk_en & imem_rsp_valid;
  assign rsp_keep = rsp_fire & ~redirect_valid & (drop == '0);
  assign pop      = clk_en & if_valid & if_ready & ~redirect_valid;

  assign if_valid = (fq_cnt != '0);
  assign if_pc    = fq_pc[fq_rd];
  assign if_instr = fq_instr[fq_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ifq_wr      <= '0;
      ifq_rd      <= '0;
      fq_wr       <= '0;
      fq_rd       <= '0;
      fq_cnt      <= '0;
      outstanding <= '0;
      drop        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        ifq[i]      <= '0;
        fq_pc[i]    <= '0;
        fq_instr[i] <= '0;
      end
    end else if (clk_en) begin
      if (redirect_valid) begin
        // Every fetch still in flight is stale; a response landing now is one of them.
        pc          <= {redirect_pc[31:2], 2'b00};
        ifq_wr      <= '0;
        ifq_rd      <= '0;
        fq_wr       <= '0;
        fq_rd       <= '0;
        fq_cnt      <= '0;
        outstanding <= outstanding - CW'(rsp_fire);
        drop        <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) begin
          ifq[ifq_wr] <= pc;
          ifq_wr      <= ifq_wr + 1'b1;
          pc          <= pc + 32'd4;
        end
        if (rsp_keep) begin
          fq_pc[fq_wr]    <= ifq[ifq_rd];
          fq_instr[fq_wr] <= imem_rsp_data;
          fq_wr           <= fq_wr + 1'b1;
          ifq_rd          <= ifq_rd + 1'b1;
        end
        if (pop)
          fq_rd <= fq_rd + 1'b1;
        fq_cnt      <= fq_cnt + CW'(rsp_keep) - CW'(pop);
        outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
        if (rsp_fire && drop != '0)
          drop <= drop - 1'b1;
      end
    end
  end

  // Credit accounting makes a kept response into a full FIFO unreachable.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_fire && !redirect_valid && drop == '0 && fq_cnt == CW'(FIFO_DEPTH)));

endmodule
